fetch_unit: RTL and testbench

Parametrised instruction-fetch front end: PC generation, single-outstanding I-memory requests, and a circular instruction queue feeding decode/ROB dispatch. It supports two control-flow modes: lazy stall (hold fetch after a jal/jalr/branch until it resolves) and predict-not-taken with redirect/flush. Stale memory responses after a redirect are discarded. It sits between the I-cache port and the decoder/ROB.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, one outstanding I-memory read,
// and a circular instruction queue toward decode. Lazy-stall or predict-not-taken.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               IQ_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h00000060),
    parameter int               BR_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_mem_resp,
    input  logic [WIDTH-1:0]              i_mem_rdata,
    output logic                          i_mem_read,
    output logic [WIDTH-1:0]              i_mem_address,
    input  logic                          iq_deq,
    output logic                          iq_valid,
    output logic [WIDTH-1:0]              iq_instr,
    output logic [WIDTH-1:0]              iq_pc,
    output logic                          iq_empty,
    output logic                          iq_full,
    output logic [$clog2(IQ_DEPTH):0]     iq_count,
    input  logic                          redirect,
    input  logic [WIDTH-1:0]              redirect_pc,
    input  logic                          br_resolve,
    output logic                          fetch_stalled,
    output logic [1:0]                    o_dbg_state
);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_req_addr;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_iq_instr [IQ_DEPTH];
    logic [WIDTH-1:0] r_iq_pc    [IQ_DEPTH];

    logic w_cf;
    logic w_flush;
    logic w_enq;
    logic w_deq;

    // Handshakes: i_mem_read rises with a request and holds i_mem_address stable
    // until the single-cycle i_mem_resp; iq_deq pops the head only when iq_valid.
    assign w_cf    = (i_mem_rdata[6:0] == 7'b1101111) || (i_mem_rdata[6:0] == 7'b1100111)
                  || (i_mem_rdata[6:0] == 7'b1100011);
    assign w_flush = redirect;
    assign w_enq   = (r_state == S_WAIT) && i_mem_resp && !redirect;
    assign w_deq   = iq_deq && (r_count != '0) && !w_flush;

    assign i_mem_read    = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign i_mem_address = r_req_addr;
    assign iq_valid      = (r_count != '0);
    assign iq_empty      = (r_count == '0);
    assign iq_full       = (r_count == DEPTH_C);
    assign iq_count      = r_count;
    assign iq_instr      = r_iq_instr[r_head];
    assign iq_pc         = r_iq_pc[r_head];
    assign fetch_stalled = (r_state == S_HOLD);
    assign o_dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + PW'(1);
                if (w_deq) r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end

            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else if (r_count < DEPTH_C) begin
                        r_req_addr <= r_pc;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= i_mem_resp ? S_FETCH : S_DRAIN;
                    end else if (i_mem_resp) begin
                        r_pc    <= r_req_addr + WIDTH'(4);
                        r_state <= (BR_MODE == 0 && w_cf) ? S_HOLD : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // The in-flight response belongs to the old path and is dropped.
                    if (redirect) r_pc <= redirect_pc;
                    if (i_mem_resp) r_state <= S_FETCH;
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_FETCH;
                    end else if (BR_MODE == 0 && br_resolve) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_iq_instr[r_tail] <= i_mem_rdata;
            r_iq_pc[r_tail]    <= r_req_addr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: lazy-stall instance (index 0) and
// predict-not-taken instance (index 1) driven by a latency-programmable memory model.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_v   = 2'b00;
    logic [1:0]        resp_v  = 2'b00;
    logic [1:0][31:0]  rdata_v = '0;
    logic [1:0]        rd_v;
    logic [1:0][31:0]  addr_v;
    logic [1:0]        deq_v   = 2'b00;
    logic [1:0]        valid_v;
    logic [1:0][31:0]  instr_v;
    logic [1:0][31:0]  pc_v;
    logic [1:0]        empty_v;
    logic [1:0]        full_v;
    logic [1:0][3:0]   cnt_v;
    logic [1:0]        redir_v = 2'b00;
    logic [1:0][31:0]  rpc_v   = '0;
    logic [1:0]        bres_v  = 2'b00;
    logic [1:0]        stall_v;
    logic [1:0][1:0]   dbg_v;

    fetch_unit #(.BR_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .i_mem_resp(resp_v[0]), .i_mem_rdata(rdata_v[0]),
        .i_mem_read(rd_v[0]), .i_mem_address(addr_v[0]), .iq_deq(deq_v[0]),
        .iq_valid(valid_v[0]), .iq_instr(instr_v[0]), .iq_pc(pc_v[0]),
        .iq_empty(empty_v[0]), .iq_full(full_v[0]), .iq_count(cnt_v[0]),
        .redirect(redir_v[0]), .redirect_pc(rpc_v[0]), .br_resolve(bres_v[0]),
        .fetch_stalled(stall_v[0]), .o_dbg_state(dbg_v[0])
    );

    fetch_unit #(.BR_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .i_mem_resp(resp_v[1]), .i_mem_rdata(rdata_v[1]),
        .i_mem_read(rd_v[1]), .i_mem_address(addr_v[1]), .iq_deq(deq_v[1]),
        .iq_valid(valid_v[1]), .iq_instr(instr_v[1]), .iq_pc(pc_v[1]),
        .iq_empty(empty_v[1]), .iq_full(full_v[1]), .iq_count(cnt_v[1]),
        .redirect(redir_v[1]), .redirect_pc(rpc_v[1]), .br_resolve(bres_v[1]),
        .fetch_stalled(stall_v[1]), .o_dbg_state(dbg_v[1])
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] br_addr0 = 32'h1;
    logic [31:0] br_addr1 = 32'h1;
    int lat [2] = '{2, 2};
    int rcnt [2] = '{0, 0};
    logic [1:0] prev_rd = 2'b00;
    logic [31:0] req_q0[$];
    logic [31:0] req_q1[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] instr_at(input int sel, input logic [31:0] a);
        logic [31:0] br;
        br = (sel == 0) ? br_addr0 : br_addr1;
        if (a == br) return 32'h00000063;
        return {a[19:0], 12'h013};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: answers each held read after lat[g] cycles, one-cycle resp.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!rst_v[g]) begin
                resp_v[g] = 1'b0;
                rcnt[g]   = 0;
            end else if (rd_v[g] && !resp_v[g]) begin
                rcnt[g]++;
                if (rcnt[g] >= lat[g]) begin
                    resp_v[g]  = 1'b1;
                    rdata_v[g] = instr_at(g, addr_v[g]);
                    rcnt[g]    = 0;
                end
            end else begin
                resp_v[g] = 1'b0;
            end
        end
    end

    // Request monitor: logs the address at each rising edge of i_mem_read.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_v[g] && rd_v[g] && !prev_rd[g]) begin
                if (g == 0) req_q0.push_back(addr_v[g]);
                else        req_q1.push_back(addr_v[g]);
            end
            prev_rd[g] = rd_v[g];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pop_req(input int sel, output logic [31:0] a);
        int n;
        n = 0;
        while (((sel == 0) ? req_q0.size() : req_q1.size()) == 0 && n < 200) begin
            tick();
            n++;
        end
        check_val("req_arrives", ((sel == 0) ? req_q0.size() : req_q1.size()) != 0, 1);
        a = 32'hDEAD_DEAD;
        if (sel == 0 && req_q0.size() != 0) a = req_q0.pop_front();
        if (sel == 1 && req_q1.size() != 0) a = req_q1.pop_front();
    endtask

    task automatic expect_req(input int sel, input string tag, input logic [31:0] exp);
        logic [31:0] a;
        pop_req(sel, a);
        check_val(tag, a, exp);
    endtask

    task automatic do_reset(input int sel, input int latency);
        rst_v[sel]   = 1'b0;
        deq_v[sel]   = 1'b0;
        redir_v[sel] = 1'b0;
        bres_v[sel]  = 1'b0;
        lat[sel]     = latency;
        tick();
        tick();
        if (sel == 0) req_q0.delete(); else req_q1.delete();
        rst_v[sel] = 1'b1;
    endtask

    task automatic pulse_redirect(input int sel, input logic [31:0] target);
        redir_v[sel] = 1'b1;
        rpc_v[sel]   = target;
        tick();
        redir_v[sel] = 1'b0;
    endtask

    task automatic wait_stall(input int sel);
        int n;
        n = 0;
        while (!stall_v[sel] && n < 100) begin
            tick();
            n++;
        end
        check_val("stall_reached", stall_v[sel], 1);
    endtask

    initial begin
        int mcount;
        int ndeq;
        int cyc;
        int n;
        logic dq;
        logic held_ok;

        // Reset values
        rst_v = 2'b00;
        tick();
        tick();
        check_val("rst_read", rd_v[0], 0);
        check_val("rst_addr", addr_v[0], 32'h60);
        check_val("rst_valid", valid_v[0], 0);
        check_val("rst_empty", empty_v[0], 1);
        check_val("rst_full", full_v[0], 0);
        check_val("rst_count", cnt_v[0], 0);
        check_val("rst_stall", stall_v[0], 0);

        // Fill: 8 sequential requests, queue full, fetch idles until one pop
        do_reset(0, 2);
        deq_v[0] = 1'b1;
        tick();
        deq_v[0] = 1'b0;
        check_val("deq_empty_count", cnt_v[0], 0);
        check_val("deq_empty_flag", empty_v[0], 1);
        for (int k = 0; k < 8; k++) expect_req(0, "fill_req", 32'h60 + 32'(4 * k));
        n = 0;
        while (cnt_v[0] != 4'd8 && n < 50) begin tick(); n++; end
        check_val("fill_count", cnt_v[0], 8);
        check_val("fill_full", full_v[0], 1);
        for (int k = 0; k < 4; k++) tick();
        check_val("full_no_read", rd_v[0], 0);
        check_val("full_no_req", req_q0.size(), 0);
        check_val("head_pc", pc_v[0], 32'h60);
        check_val("head_instr", instr_v[0], instr_at(0, 32'h60));
        deq_v[0] = 1'b1;
        tick();
        deq_v[0] = 1'b0;
        expect_req(0, "after_deq_req", 32'h80);
        check_val("after_deq_count", cnt_v[0], 7);
        check_val("after_deq_head", pc_v[0], 32'h64);

        // Lazy stall on branch at 0x68, released by br_resolve
        br_addr0 = 32'h68;
        do_reset(0, 2);
        expect_req(0, "br_req0", 32'h60);
        expect_req(0, "br_req1", 32'h64);
        expect_req(0, "br_req2", 32'h68);
        wait_stall(0);
        check_val("hold_count", cnt_v[0], 3);
        for (int k = 0; k < 5; k++) tick();
        check_val("hold_no_read", rd_v[0], 0);
        check_val("hold_no_req", req_q0.size(), 0);
        check_val("hold_still", stall_v[0], 1);
        bres_v[0] = 1'b1;
        tick();
        bres_v[0] = 1'b0;
        expect_req(0, "resolve_req", 32'h6C);
        check_val("resolve_unstall", stall_v[0], 0);

        // Redirect out of hold flushes the queue
        do_reset(0, 2);
        for (int k = 0; k < 3; k++) expect_req(0, "hold2_req", 32'h60 + 32'(4 * k));
        wait_stall(0);
        pulse_redirect(0, 32'h200);
        check_val("hold_redir_count", cnt_v[0], 0);
        check_val("hold_redir_empty", empty_v[0], 1);
        check_val("hold_redir_stall", stall_v[0], 0);
        expect_req(0, "hold_redir_req", 32'h200);
        br_addr0 = 32'h1;

        // Redirect while 0x70 is outstanding: address held, data dropped
        do_reset(0, 4);
        for (int k = 0; k < 5; k++) expect_req(0, "drain_pre", 32'h60 + 32'(4 * k));
        pulse_redirect(0, 32'h300);
        check_val("drain_read", rd_v[0], 1);
        check_val("drain_addr", addr_v[0], 32'h70);
        check_val("drain_flush", cnt_v[0], 0);
        held_ok = 1'b1;
        n = 0;
        while (rd_v[0] && n < 50) begin
            if (addr_v[0] != 32'h70) held_ok = 1'b0;
            tick();
            n++;
        end
        check_val("drain_held", held_ok, 1);
        expect_req(0, "drain_next_req", 32'h300);
        check_val("drain_count", cnt_v[0], 0);

        // Predict-not-taken: no stall on branch, redirect coincident with resp
        br_addr1 = 32'h64;
        do_reset(1, 2);
        for (int k = 0; k < 4; k++) expect_req(1, "pnt_req", 32'h60 + 32'(4 * k));
        check_val("pnt_no_stall", stall_v[1], 0);
        check_val("pnt_count", cnt_v[1], 3);
        check_val("pnt_head", pc_v[1], 32'h60);
        n = 0;
        while (!resp_v[1] && n < 20) begin tick(); n++; end
        check_val("pnt_resp_addr", addr_v[1], 32'h6C);
        pulse_redirect(1, 32'h400);
        check_val("pnt_drop_count", cnt_v[1], 0);
        expect_req(1, "pnt_redir_req", 32'h400);
        check_val("pnt_after_count", cnt_v[1], 0);

        // Wrap: 20 pops with random deq, order and occupancy against a model
        do_reset(0, 1);
        exp_q.delete();
        for (int k = 0; k < 40; k++) exp_q.push_back(32'h60 + 32'(4 * k));
        mcount = 0;
        ndeq = 0;
        cyc = 0;
        while (ndeq < 20 && cyc < 600) begin
            tick();
            cyc++;
            check_val("wrap_count", cnt_v[0], mcount);
            dq = ($urandom_range(0, 1) == 1);
            if (dq && mcount > 0) begin
                check_val("wrap_pc", pc_v[0], exp_q[0]);
                check_val("wrap_instr", instr_v[0], instr_at(0, exp_q[0]));
                void'(exp_q.pop_front());
                ndeq++;
            end
            deq_v[0] = dq;
            mcount = mcount + (resp_v[0] ? 1 : 0) - ((dq && mcount > 0) ? 1 : 0);
        end
        deq_v[0] = 1'b0;
        check_val("wrap_pops", ndeq, 20);

        // Asynchronous reset in the middle of WAIT
        n = 0;
        while (!rd_v[0] && n < 50) begin tick(); n++; end
        check_val("mid_wait_read", rd_v[0], 1);
        #2;
        rst_v[0] = 1'b0;
        #1;
        check_val("async_read", rd_v[0], 0);
        check_val("async_addr", addr_v[0], 32'h60);
        check_val("async_count", cnt_v[0], 0);
        check_val("async_valid", valid_v[0], 0);
        tick();
        tick();
        req_q0.delete();
        rst_v[0] = 1'b1;
        expect_req(0, "post_reset_req", 32'h60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
